maindec_pipe: RTL

//  Registered, parametrised successor of the combinational main decoder. Sits between the IF/ID

---
 rtl/maindec_pipe.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/maindec_pipe.sv
// maindec_pipe: registered MIPS32 main decoder between IF/ID and ID/EX.
// Decodes at accept time and holds the control bundle behind a valid/ready
// handshake, with an optional second (skid) entry. It also tracks branch delay
// slots, encodes RI/Sys/Bp exceptions and counts reserved instructions.
module maindec_pipe #(
    parameter int unsigned PC_W    = 32,
    parameter bit          SKID_EN = 1'b1,
    parameter bit          CP0_EN  = 1'b1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr_in,
    input  logic [PC_W-1:0]   pc_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [10:0]       ctrl_out,
    output logic              memread_out,
    output logic [2:0]        cp0_out,
    output logic [4:0]        exc_out,
    output logic              in_ds_out,
    output logic [31:0]       instr_out,
    output logic [PC_W-1:0]   pc_out,
    output logic [CNT_W-1:0]  ri_count
);

    localparam int unsigned CTRL_W    = 11;
    localparam int unsigned BIT_BRANCH = 7;
    localparam int unsigned BIT_JUMP   = 4;

    localparam logic [4:0] EXC_NONE = 5'h00;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;

    localparam logic [CTRL_W-1:0] CTRL_RALU   = 11'b11000000000;
    localparam logic [CTRL_W-1:0] CTRL_HILO   = 11'b00000001000;
    localparam logic [CTRL_W-1:0] CTRL_JR     = 11'b00000010010;
    localparam logic [CTRL_W-1:0] CTRL_JALR   = 11'b11000010011;
    localparam logic [CTRL_W-1:0] CTRL_IMM    = 11'b10100000000;
    localparam logic [CTRL_W-1:0] CTRL_BR     = 11'b00010000000;
    localparam logic [CTRL_W-1:0] CTRL_BRAL   = 11'b10010000101;
    localparam logic [CTRL_W-1:0] CTRL_J      = 11'b00000010000;
    localparam logic [CTRL_W-1:0] CTRL_JAL    = 11'b10000010101;
    localparam logic [CTRL_W-1:0] CTRL_LOAD   = 11'b10100100000;
    localparam logic [CTRL_W-1:0] CTRL_STORE  = 11'b00101000000;
    localparam logic [CTRL_W-1:0] CTRL_MFC0   = 11'b10000000000;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic              memread;
        logic [2:0]        cp0;
        logic [4:0]        exc;
        logic              in_ds;
        logic [31:0]       instr;
        logic [PC_W-1:0]   pc;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e            state_q;
    entry_t            head_q;
    entry_t            skid_q;
    entry_t            entry_d;
    logic              ds_q;
    logic              rdy_q;
    logic [CNT_W-1:0]  ri_cnt_q;

    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_memread;
    logic [2:0]        dec_cp0;
    logic [4:0]        dec_exc;
    logic              dec_ri;
    logic              accept;
    logic              emit;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;

    assign op    = instr_in[31:26];
    assign funct = instr_in[5:0];
    assign rs    = instr_in[25:21];
    assign rt    = instr_in[20:16];

    // Instruction decode; anything not recognised becomes a reserved instruction.
    always_comb begin
        dec_ctrl    = '0;
        dec_memread = 1'b0;
        dec_exc     = EXC_NONE;
        dec_ri      = 1'b0;
        case (op)
            6'b000000: begin
                case (funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h10, 6'h12,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B:                    dec_ctrl = CTRL_RALU;
                    6'h11, 6'h13,
                    6'h18, 6'h19, 6'h1A, 6'h1B:      dec_ctrl = CTRL_HILO;
                    6'h08:                           dec_ctrl = CTRL_JR;
                    6'h09:                           dec_ctrl = CTRL_JALR;
                    6'h0C:                           dec_exc  = EXC_SYS;
                    6'h0D:                           dec_exc  = EXC_BP;
                    default:                         dec_ri   = 1'b1;
                endcase
            end
            6'b000001: begin
                case (rt)
                    5'b00000, 5'b00001:              dec_ctrl = CTRL_BR;
                    5'b10000, 5'b10001:              dec_ctrl = CTRL_BRAL;
                    default:                         dec_ri   = 1'b1;
                endcase
            end
            6'b000010:                               dec_ctrl = CTRL_J;
            6'b000011:                               dec_ctrl = CTRL_JAL;
            6'b000100, 6'b000101,
            6'b000110, 6'b000111:                    dec_ctrl = CTRL_BR;
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110, 6'b001111: dec_ctrl = CTRL_IMM;
            6'b010000: begin
                if (!CP0_EN) begin
                    dec_ri = 1'b1;
                end else begin
                    case (rs)
                        5'b00000:                    dec_ctrl = CTRL_MFC0;
                        5'b00100, 5'b10000:          dec_ctrl = '0;
                        default:                     dec_ri   = 1'b1;
                    endcase
                end
            end
            6'b100000, 6'b100001, 6'b100011,
            6'b100100, 6'b100101: begin
                dec_ctrl    = CTRL_LOAD;
                dec_memread = 1'b1;
            end
            6'b101000, 6'b101001, 6'b101011:         dec_ctrl = CTRL_STORE;
            default:                                 dec_ri   = 1'b1;
        endcase

        dec_cp0[2] = CP0_EN && (instr_in[31:21] == 11'b01000000100) && (instr_in[10:0] == 11'd0);
        dec_cp0[1] = CP0_EN && (instr_in[31:21] == 11'b01000000000) && (instr_in[10:0] == 11'd0);
        dec_cp0[0] = CP0_EN && (instr_in == 32'h42000018);

        if (dec_ri) begin
            dec_ctrl    = '0;
            dec_memread = 1'b0;
            dec_cp0     = '0;
            dec_exc     = EXC_RI;
        end
    end

    // Entry captured on accept; delay-slot flag reflects the previous accepted entry.
    always_comb begin
        entry_d.ctrl    = dec_ctrl;
        entry_d.memread = dec_memread;
        entry_d.cp0     = dec_cp0;
        entry_d.exc     = dec_exc;
        entry_d.in_ds   = ds_q;
        entry_d.instr   = instr_in;
        entry_d.pc      = pc_in;
    end

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = SKID_EN ? rdy_q : (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

    // Holding FSM: head entry drives the outputs, skid entry drains into it first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            head_q   <= '0;
            skid_q   <= '0;
            ds_q     <= 1'b0;
            rdy_q    <= 1'b1;
            ri_cnt_q <= '0;
        end else if (flush) begin
            state_q  <= ST_EMPTY;
            ds_q     <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            rdy_q <= 1'b1;
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        head_q  <= entry_d;
                        state_q <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && emit) begin
                        head_q  <= entry_d;
                    end else if (accept) begin
                        skid_q  <= entry_d;
                        state_q <= ST_FULL;
                        rdy_q   <= 1'b0;
                    end else if (emit) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (emit) begin
                        head_q  <= skid_q;
                        state_q <= ST_ONE;
                    end else begin
                        rdy_q   <= 1'b0;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
            if (accept) begin
                ds_q <= entry_d.ctrl[BIT_BRANCH] | entry_d.ctrl[BIT_JUMP];
                if (dec_ri && (ri_cnt_q != '1)) begin
                    ri_cnt_q <= ri_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign ctrl_out    = head_q.ctrl;
    assign memread_out = head_q.memread;
    assign cp0_out     = head_q.cp0;
    assign exc_out     = head_q.exc;
    assign in_ds_out   = head_q.in_ds;
    assign instr_out   = head_q.instr;
    assign pc_out      = head_q.pc;
    assign ri_count    = ri_cnt_q;

endmodule
